// File: rtl/definitions_pkg.sv
// Shared UART definitions: clocking constants and transmitter FSM state type.
package definitions_pkg;

  localparam int unsigned CLOCK_PERIOD_NANOS = 20;
  localparam int unsigned DIVISOR            = 27;
  localparam int unsigned OVERSAMPLE_RATE    = 16;
  localparam int unsigned DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage : definitions_pkg

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts oversampling ticks and flags the tick that ends a bit.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE_RATE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic s_tick,
  output logic bit_end
);

  localparam int unsigned CW = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE_RATE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: held at zero while cleared, wraps after the last tick of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (s_tick) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = s_tick && !clear && (cnt_q == LAST);

endmodule : uart_bit_timer

// File: rtl/uart_transmitter.sv
// UART transmit engine: start bit, LSB-first data, optional parity, stop bits.
module uart_transmitter
  import definitions_pkg::*;
#(
  parameter int unsigned DATA_BITS       = DATA_BITS_DEFAULT,
  parameter int unsigned OVERSAMPLE_RATE = definitions_pkg::OVERSAMPLE_RATE,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned PARITY_EN       = 0,
  parameter int unsigned PARITY_ODD      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enabled,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 s_tick,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned STOP_TICKS = STOP_BITS * OVERSAMPLE_RATE;
  localparam int unsigned SW = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TICKS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] shift_next;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timer_clear;
  logic                 bit_end;

  // The bit timer only runs for start/data/parity bits; stop has its own counter
  // so multi-bit stop phases end on a single terminal count.
  assign timer_clear = (state_q == IDLE) || (state_q == STOP);

  uart_bit_timer #(
    .OVERSAMPLE_RATE(OVERSAMPLE_RATE)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .s_tick (s_tick),
    .bit_end(bit_end)
  );

  assign shift_next = shift_q >> 1;

  // Next-state and next-output logic; the line value is computed one edge ahead
  // so out is always a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (start && tx_enabled) begin
          shift_d    = data_in;
          parity_d   = (^data_in) ^ ODD_BIT;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = START;
          out_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          out_d   = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              out_d   = parity_q;
            end else begin
              state_d = STOP;
              out_d   = 1'b1;
            end
          end else begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 1'b1;
            out_d     = shift_next[0];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          out_d   = 1'b1;
        end
      end

      STOP: begin
        out_d = 1'b1;
        if (s_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = '0;
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a tick-driven line receiver model.
module tb_uart_transmitter;

  localparam int TDIV     = 4;
  localparam int BIT_CLKS = 16 * TDIV;

  logic       clk = 1'b0;
  logic       s_tick = 1'b0;
  logic       reset, tx_enabled, start, start_p;
  logic [7:0] data_in;
  logic       out, busy, done;
  logic       out_pe, busy_pe, done_pe;
  logic       out_po, busy_po, done_po;

  int         checks = 0;
  int         failures = 0;
  int         tick_div = 0;
  logic [8:0] rx_q[$];
  logic [7:0] mon_b;

  always #5 clk = ~clk;

  // Free-running oversampling tick, one clk wide every TDIV clks.
  always @(posedge clk) begin
    if (tick_div == TDIV - 1) begin
      tick_div <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_div <= tick_div + 1;
      s_tick   <= 1'b0;
    end
  end

  uart_transmitter #(
    .DATA_BITS(8), .OVERSAMPLE_RATE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .reset(reset), .tx_enabled(tx_enabled), .start(start),
    .data_in(data_in), .s_tick(s_tick), .out(out), .busy(busy), .done(done)
  );

  uart_transmitter #(
    .DATA_BITS(8), .OVERSAMPLE_RATE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_pe (
    .clk(clk), .reset(reset), .tx_enabled(tx_enabled), .start(start_p),
    .data_in(data_in), .s_tick(s_tick), .out(out_pe), .busy(busy_pe), .done(done_pe)
  );

  uart_transmitter #(
    .DATA_BITS(8), .OVERSAMPLE_RATE(16), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut_po (
    .clk(clk), .reset(reset), .tx_enabled(tx_enabled), .start(start_p),
    .data_in(data_in), .s_tick(s_tick), .out(out_po), .busy(busy_po), .done(done_po)
  );

  task automatic mon_wait(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (s_tick === 1'b1) c++;
    end
  endtask

  // Receiver model on the main line: mid-bit sampling by tick count.
  always begin
    @(negedge clk);
    if (out === 1'b0 && reset === 1'b0) begin
      mon_wait(8);
      if (out === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          mon_wait(16);
          mon_b[i] = out;
        end
        mon_wait(16);
        rx_q.push_back({out, mon_b});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (busy !== 1'b0 || busy_pe !== 1'b0 || busy_po !== 1'b0); i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_rx1(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = (rx_q.size() > 0) ? rx_q[0] : 9'hxxx;
    checks++;
    if (rx_q.size() != 1 || got !== exp) begin
      failures++;
      $display("FAIL %s rx_count=%0d got=%h exp=%h", name, rx_q.size(), got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (out !== 1'b1) begin failures++; $display("FAIL reset_out got=%b exp=1", out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (out_po !== 1'b1) begin failures++; $display("FAIL reset_out_po got=%b exp=1", out_po); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [9:0] exp_bits;
    int nbusy, ndone;
    bit gap;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    nbusy = 1; ndone = 0; gap = 1'b0;
    rx_q.delete();
    send_byte(8'hA5);
    checks++; if (out !== 1'b0) begin failures++; $display("FAIL accept_out got=%b exp=0", out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL accept_busy got=%b exp=1", busy); end
    for (int n = 2; n <= 700; n++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
      if (busy !== 1'b1 && ndone == 0) gap = 1'b1;
      if (n % BIT_CLKS == 32 && n / BIT_CLKS < 10) begin
        checks++;
        if (out !== exp_bits[n / BIT_CLKS]) begin
          failures++;
          $display("FAIL a5_bit%0d got=%b exp=%b", n / BIT_CLKS, out, exp_bits[n / BIT_CLKS]);
        end
      end
    end
    checks++; if (ndone != 1) begin failures++; $display("FAIL a5_done_pulses got=%0d exp=1", ndone); end
    checks++; if (nbusy < 637 || nbusy > 640) begin failures++; $display("FAIL a5_busy_len got=%0d exp=637..640", nbusy); end
    checks++; if (gap) begin failures++; $display("FAIL a5_busy_gap got=1 exp=0"); end
    checks++; if (busy !== 1'b0 || out !== 1'b1) begin failures++; $display("FAIL a5_after busy=%b out=%b exp busy=0 out=1", busy, out); end
    check_rx1("a5_rx", 9'h1A5);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [8];
    bit ok;
    bytes = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    wait_idle();
    rx_q.delete();
    send_byte(bytes[0]);
    for (int i = 1; i < 8; i++) begin
      wait_done(800, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_done%0d got=timeout exp=done", i - 1); end
      data_in = bytes[i];
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      checks++;
      if (out !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap%0d out=%b busy=%b exp out=0 busy=1", i, out, busy);
      end
    end
    wait_done(800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done7 got=timeout exp=done"); end
    checks++; if (rx_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {1'b1, bytes[i]}) begin
        failures++;
        $display("FAIL b2b_rx%0d got=%h exp=%h", i, rx_q[i], {1'b1, bytes[i]});
      end
    end
  endtask

  task automatic test_ignored_mid();
    bit ok;
    wait_idle();
    rx_q.delete();
    send_byte(8'h66);
    repeat (200) @(negedge clk);
    data_in = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_done got=timeout exp=done"); end
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (busy !== 1'b0 || out !== 1'b1) begin failures++; $display("FAIL mid_no_second busy=%b out=%b exp busy=0 out=1", busy, out); end
    check_rx1("mid_rx", 9'h166);
  endtask

  task automatic test_disabled();
    int viol;
    viol = 0;
    wait_idle();
    rx_q.delete();
    tx_enabled = 1'b0;
    data_in    = 8'h81;
    start      = 1'b1;
    repeat (20 * BIT_CLKS) begin
      @(negedge clk);
      if (out !== 1'b1 || busy !== 1'b0) viol++;
    end
    start      = 1'b0;
    tx_enabled = 1'b1;
    checks++; if (viol != 0) begin failures++; $display("FAIL disabled_line got=%0d bad cycles exp=0", viol); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL disabled_rx got=%0d frames exp=0", rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    bit ok;
    ndone = 0;
    wait_idle();
    send_byte(8'h00);
    repeat (4 * BIT_CLKS + 31) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out !== 1'b1) begin failures++; $display("FAIL rstmid_out got=%b exp=1", out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    repeat (12 * BIT_CLKS) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    rx_q.delete();
    send_byte(8'h12);
    wait_done(800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_resend_done got=timeout exp=done"); end
    check_rx1("rstmid_rx", 9'h112);
  endtask

  task automatic test_enable_drop();
    bit ok;
    wait_idle();
    rx_q.delete();
    send_byte(8'h56);
    repeat (200) @(negedge clk);
    tx_enabled = 1'b0;
    wait_done(800, ok);
    tx_enabled = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL endrop_done got=timeout exp=done"); end
    check_rx1("endrop_rx", 9'h156);
  endtask

  task automatic test_parity();
    int nb_pe, nb_po, nd_pe, nd_po;
    nb_pe = 0; nb_po = 0; nd_pe = 0; nd_po = 0;
    wait_idle();
    @(negedge clk);
    data_in = 8'h07;
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    for (int n = 1; n <= 800; n++) begin
      if (n > 1) @(negedge clk);
      if (busy_pe === 1'b1) nb_pe++;
      if (busy_po === 1'b1) nb_po++;
      if (done_pe === 1'b1) nd_pe++;
      if (done_po === 1'b1) nd_po++;
      if (n == 2 * BIT_CLKS + 32) begin
        checks++; if (out_pe !== 1'b1) begin failures++; $display("FAIL par_data1 got=%b exp=1", out_pe); end
      end
      if (n == 9 * BIT_CLKS + 32) begin
        checks++; if (out_pe !== 1'b1) begin failures++; $display("FAIL par_even_bit got=%b exp=1", out_pe); end
        checks++; if (out_po !== 1'b0) begin failures++; $display("FAIL par_odd_bit got=%b exp=0", out_po); end
      end
      if (n == 10 * BIT_CLKS + 32) begin
        checks++; if (out_pe !== 1'b1 || out_po !== 1'b1) begin failures++; $display("FAIL par_stop1 pe=%b po=%b exp 1 1", out_pe, out_po); end
      end
      if (n == 11 * BIT_CLKS + 32) begin
        checks++;
        if (busy_pe !== 1'b0 || busy_po !== 1'b1 || out_po !== 1'b1) begin
          failures++;
          $display("FAIL par_stop2 busy_pe=%b busy_po=%b out_po=%b exp 0 1 1", busy_pe, busy_po, out_po);
        end
      end
    end
    checks++; if (nd_pe != 1 || nd_po != 1) begin failures++; $display("FAIL par_done pe=%0d po=%0d exp 1 1", nd_pe, nd_po); end
    checks++; if (nb_pe < 701 || nb_pe > 704) begin failures++; $display("FAIL par_pe_len got=%0d exp=701..704", nb_pe); end
    checks++; if (nb_po < 765 || nb_po > 768) begin failures++; $display("FAIL par_po_len got=%0d exp=765..768", nb_po); end
  endtask

  initial begin
    reset      = 1'b1;
    tx_enabled = 1'b1;
    start      = 1'b0;
    start_p    = 1'b0;
    data_in    = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_mid();
    test_disabled();
    test_reset_mid();
    test_enable_drop();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_transmitter

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART transmit engine that serialises one byte per request onto a single line: idle high, 1 start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits. It is paced by the shared oversampling tick from baud_gen (OVERSAMPLE_RATE ticks per bit), so line timing matches the receiver on the same tick. It sits between the host-side byte source and the serial pin. Loopback into the receiver block is the primary system check.

Parameters:
DATA_BITS, 8, payload bits per frame.
OVERSAMPLE_RATE, definitions_pkg::OVERSAMPLE_RATE (16), s_tick pulses per bit period.
STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.
PARITY_EN, 0, when 1, insert a parity bit after the data.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_enabled  input  1  transmitter enable; gates acceptance of new frames only
start  input  1  request to send data_in; sampled only in IDLE
data_in  input  DATA_BITS  byte to send; latched when start is accepted
s_tick  input  1  one-clk-wide oversampling tick from baud_gen
out  output  1  serial line, registered
busy  output  1  high from the cycle after acceptance until the frame ends
done  output  1  one-cycle pulse at the end of the frame

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out=1, busy=0, done=0, tick counter=0, bit counter=0, shift register=0. A reset asserted mid-frame aborts the frame; out returns high at the next edge and done is not pulsed.
- FSM states: IDLE, START, DATA, PARITY, STOP (tx_state_t).
- Acceptance: in IDLE, start=1 and tx_enabled=1 on a clk edge -> latch data_in, compute parity, go to START, and clear the tick counter.
  - On that same edge, out=0 and busy=1, so both are visible the cycle after acceptance.
  - start with tx_enabled=0 is ignored.
  - start outside IDLE is ignored; there is no queueing.
- Bit timing: the tick counter advances only on s_tick. A bit ends on the s_tick where the counter equals OVERSAMPLE_RATE-1; the counter then wraps to 0.
  - Each bit therefore lasts exactly OVERSAMPLE_RATE ticks, i.e. OVERSAMPLE_RATE*DIVISOR clks.
  - The first bit may be short by up to one tick period, because tick phase is free-running.
- START -> DATA: out=shift[0]. In DATA, each bit end shifts right and increments the bit counter. After bit DATA_BITS-1 ends, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: out = XOR of the latched data, inverted when PARITY_ODD=1. Lasts one bit period, then goes to STOP.
- STOP: out=1 for STOP_BITS*OVERSAMPLE_RATE ticks. On the final tick's edge: state=IDLE, busy=0, done=1 for exactly one cycle.
- Back-to-back: in the cycle where done=1, the FSM is already in IDLE. start accepted in that cycle begins the next start bit immediately, with no extra idle bit.
- tx_enabled falling mid-frame does not abort; the current frame completes normally.
- data_in changes after acceptance have no effect on the frame in flight.
- out is driven only from a flop; it has no combinational path from the inputs.
- Width rules:
  - tick counter width = $clog2(OVERSAMPLE_RATE).
  - bit counter width = $clog2(DATA_BITS).
  - stop counter sized to STOP_BITS*OVERSAMPLE_RATE.

Decomposition:
- definitions_pkg: add tx_state_t (enum logic [2:0]: IDLE, START, DATA, PARITY, STOP). Reuse the existing DIVISOR, OVERSAMPLE_RATE and CLOCK_PERIOD_NANOS; add DATA_BITS_DEFAULT=8.
- One sub-module is natural: uart_bit_timer, which wraps the tick counter and emits bit_end. The FSM datapath stays in uart_transmitter.
- baud_gen is instantiated outside this block, at the top or in the bench.

Test Plan:
- Single frame: send 8'hA5 with default parameters. Required line sequence, each bit lasting 16*DIVISOR clks ±1 tick: 0, 1,0,1,0,0,1,0,1, 1. busy is high for the entire frame; done pulses once; afterwards busy=0 and out=1.
- Back-to-back loopback into the receiver: send A5, 5A, FF, 00, 12, 34, 56, 78, issuing start in each done cycle. The receiver must output the same 8 bytes in order, and no idle gap may exceed 1 clk.
- Ignored requests:
  - start pulsed mid-frame with data_in=8'h3C -> the frame in flight still carries the original byte, and no second frame follows.
  - start with tx_enabled=0 -> out stays 1 and busy stays 0 for 20 bit periods.
- Reset mid-frame: assert reset during data bit 3 of 8'h00. Required response: out=1, busy=0, done=0 on the next edge. A fresh send of 8'h12 afterwards must then be received correctly.
- Parity: set PARITY_EN=1, PARITY_ODD=0 and send 8'h07 -> parity bit=1. With PARITY_ODD=1, parity bit=0. With STOP_BITS=2, the stop phase lasts 32 ticks.
- Enable drop: deassert tx_enabled during the DATA state of 8'h56. The frame must complete and done must pulse.
